// File: rtl/if_fetch.sv
// if_fetch: IF-stage PC and instruction-fetch controller with a one-word hold buffer.
// Revision 1.0
`default_nettype none

module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        id_stall,
  input  logic        redirect,
  input  logic [31:0] target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc4,
  output logic [31:0] if_inst,
  output logic        if_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [31:0] PC_RST = RESET_PC & ~32'h3;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ibuf_q, ibuf_d;
  logic [31:0] next_pc;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= S_IDLE;
      pc_q    <= PC_RST;
      ibuf_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ibuf_q  <= ibuf_d;
    end
  end

  // Redirect only matters on cycles where pc actually advances.
  assign next_pc = redirect ? (target & ~32'h3) : (pc_q + 32'd4);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ibuf_d   = ibuf_q;
    imem_req = 1'b0;
    if_inst  = '0;
    if_busy  = 1'b1;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        imem_req = 1'b1;
        if_busy  = ~imem_ack;
        if (imem_ack) begin
          if_inst = imem_rdata;
          if (id_stall) begin
            ibuf_d  = imem_rdata;
            state_d = S_HOLD;
          end else begin
            pc_d = next_pc;
          end
        end
      end
      S_HOLD: begin
        if_busy = 1'b0;
        if_inst = ibuf_q;
        if (!id_stall) begin
          pc_d    = next_pc;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_addr = {pc_q[31:2], 2'b00};
  assign if_pc4    = pc_q + 32'd4;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch.sv
// tb_if_fetch: table-driven directed bench for if_fetch.
`default_nettype none

module tb_if_fetch;

  logic        clk = 1'b0;
  logic        clrn;
  logic        id_stall, redirect, imem_ack;
  logic [31:0] target;
  logic        imem_req, if_busy;
  logic [31:0] imem_addr, imem_rdata, if_pc4, if_inst;

  int checks = 0;
  int errors = 0;

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .clrn(clrn), .id_stall(id_stall), .redirect(redirect), .target(target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_pc4(if_pc4), .if_inst(if_inst), .if_busy(if_busy)
  );

  always #5 clk = ~clk;

  // Memory model: word = addr ^ A5A5_0000 when acked, garbage otherwise.
  always_comb imem_rdata = imem_ack ? (imem_addr ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] tgt;
    logic        ack;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_busy;
    logic [31:0] e_inst;
    logic [31:0] e_pc4;
  } vec_t;

  localparam int N = 26;
  vec_t vecs[N];

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] t, input logic a,
                              input logic eq, input logic [31:0] ea, input logic eb,
                              input logic [31:0] ei, input logic [31:0] ep);
    vec_t v;
    v.stall = s; v.redir = r; v.tgt = t; v.ack = a;
    v.e_req = eq; v.e_addr = ea; v.e_busy = eb; v.e_inst = ei; v.e_pc4 = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic eq, input logic [31:0] ea,
                         input logic eb, input logic [31:0] ei, input logic [31:0] ep);
    chk({tag, ".req"},  {31'd0, imem_req}, {31'd0, eq});
    chk({tag, ".addr"}, imem_addr, ea);
    chk({tag, ".busy"}, {31'd0, if_busy}, {31'd0, eb});
    chk({tag, ".inst"}, if_inst, ei);
    chk({tag, ".pc4"},  if_pc4, ep);
  endtask

  initial begin
    //                 stall redir target        ack  req addr          busy inst                pc4
    vecs[0]  = mk(0, 0, 32'h0,         0,   0, 32'h0,         1, 32'h0,            32'h4);        // idle
    vecs[1]  = mk(0, 0, 32'h0,         1,   1, 32'h0,         0, f(32'h0),         32'h4);
    vecs[2]  = mk(0, 0, 32'h0,         1,   1, 32'h4,         0, f(32'h4),         32'h8);
    vecs[3]  = mk(0, 0, 32'h0,         0,   1, 32'h8,         1, 32'h0,            32'hC);        // wait
    vecs[4]  = mk(0, 0, 32'h0,         0,   1, 32'h8,         1, 32'h0,            32'hC);
    vecs[5]  = mk(0, 0, 32'h0,         1,   1, 32'h8,         0, f(32'h8),         32'hC);
    vecs[6]  = mk(0, 0, 32'h0,         1,   1, 32'hC,         0, f(32'hC),         32'h10);
    vecs[7]  = mk(1, 0, 32'h0,         1,   1, 32'h10,        0, f(32'h10),        32'h14);       // -> hold
    vecs[8]  = mk(1, 1, 32'h200,       1,   0, 32'h10,        0, f(32'h10),        32'h14);
    vecs[9]  = mk(1, 0, 32'h0,         0,   0, 32'h10,        0, f(32'h10),        32'h14);
    vecs[10] = mk(0, 0, 32'h0,         0,   0, 32'h10,        0, f(32'h10),        32'h14);
    vecs[11] = mk(0, 0, 32'h0,         1,   1, 32'h14,        0, f(32'h14),        32'h18);
    vecs[12] = mk(0, 0, 32'h0,         1,   1, 32'h18,        0, f(32'h18),        32'h1C);
    vecs[13] = mk(0, 0, 32'h0,         1,   1, 32'h1C,        0, f(32'h1C),        32'h20);
    vecs[14] = mk(0, 1, 32'h103,       1,   1, 32'h20,        0, f(32'h20),        32'h24);       // delay slot
    vecs[15] = mk(0, 0, 32'h0,         1,   1, 32'h100,       0, f(32'h100),       32'h104);
    vecs[16] = mk(0, 1, 32'h40,        1,   1, 32'h104,       0, f(32'h104),       32'h108);
    vecs[17] = mk(0, 1, 32'hFFFF_FFFF, 0,   1, 32'h40,        1, 32'h0,            32'h44);
    vecs[18] = mk(0, 1, 32'hFFFF_FFFF, 0,   1, 32'h40,        1, 32'h0,            32'h44);
    vecs[19] = mk(0, 1, 32'hFFFF_FFFF, 0,   1, 32'h40,        1, 32'h0,            32'h44);
    vecs[20] = mk(0, 1, 32'hFFFF_FFFF, 1,   1, 32'h40,        0, f(32'h40),        32'h44);
    vecs[21] = mk(0, 0, 32'h0,         1,   1, 32'hFFFF_FFFC, 0, f(32'hFFFF_FFFC), 32'h0);        // wrap
    vecs[22] = mk(0, 0, 32'h0,         1,   1, 32'h0,         0, f(32'h0),         32'h4);
    vecs[23] = mk(1, 1, 32'h80,        0,   1, 32'h4,         1, 32'h0,            32'h8);
    vecs[24] = mk(0, 0, 32'h0,         1,   1, 32'h4,         0, f(32'h4),         32'h8);
    vecs[25] = mk(0, 1, 32'h30,        1,   1, 32'h8,         0, f(32'h8),         32'hC);

    clrn = 1'b0; id_stall = 1'b0; redirect = 1'b0; target = '0; imem_ack = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 chk_all("reset", 1'b0, 32'h0, 1'b1, 32'h0, 32'h4);
    clrn = 1'b1;

    for (int i = 0; i < N; i++) begin
      id_stall = vecs[i].stall;
      redirect = vecs[i].redir;
      target   = vecs[i].tgt;
      imem_ack = vecs[i].ack;
      #1 chk_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_busy,
                 vecs[i].e_inst, vecs[i].e_pc4);
      @(negedge clk);
    end

    // Asynchronous reset during an outstanding request at pc=30.
    id_stall = 1'b0; redirect = 1'b0; target = '0; imem_ack = 1'b0;
    #1 chk_all("pre_rst", 1'b1, 32'h30, 1'b1, 32'h0, 32'h34);
    #1 clrn = 1'b0;
    #1 chk_all("async_rst", 1'b0, 32'h0, 1'b1, 32'h0, 32'h4);
    @(negedge clk);
    clrn = 1'b1;
    imem_ack = 1'b1;
    #1 chk_all("post_idle", 1'b0, 32'h0, 1'b1, 32'h0, 32'h4);
    @(negedge clk);
    imem_ack = 1'b0;
    #1 chk_all("post_req", 1'b1, 32'h0, 1'b1, 32'h0, 32'h4);
    imem_ack = 1'b1;
    #1 chk_all("post_ack", 1'b1, 32'h0, 1'b0, f(32'h0), 32'h4);
    @(negedge clk);
    #1 chk_all("post_next", 1'b1, 32'h4, 1'b0, f(32'h4), 32'h8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
